// File: rtl/crc_chk_byteen.sv
// Receive-side CRC checker for a byte-enabled streaming datapath.
// Each frame (payload followed by its FCS) runs through the CRC. The final
// register is compared against a fixed residue, giving one pass/fail strobe
// per frame. Malformed byte-enable framing and runt frames are flagged.
// Saturating frame and error counters feed the link status block.
module crc_chk_byteen #(
    parameter int                   DWIDTH    = 512,
    parameter int                   CRC_WIDTH = 16,
    parameter int                   PIPE_LVL  = 0,
    parameter logic [CRC_WIDTH-1:0] CRC_POLY  = 16'hda5f,
    parameter logic [CRC_WIDTH-1:0] INIT      = 16'h0000,
    parameter logic                 REFIN     = 1'b0,
    parameter logic [CRC_WIDTH-1:0] RESIDUE   = 16'h0000,
    parameter int                   CNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DWIDTH-1:0]      din,
    input  logic [DWIDTH/8-1:0]    byteEn,
    input  logic                   dlast,
    input  logic                   flitEn,
    output logic                   chk_vld,
    output logic                   chk_ok,
    output logic                   chk_crc_err,
    output logic                   chk_fmt_err,
    output logic [CNT_WIDTH-1:0]   frame_cnt,
    output logic [CNT_WIDTH-1:0]   err_cnt
);

    localparam int NB  = DWIDTH / 8;
    localparam int LG  = $clog2(NB);
    localparam int CB  = CRC_WIDTH / 8;
    localparam int CBW = $clog2(CB + 1);
    localparam int SW  = LG + CBW + 1;
    localparam int BW  = 3 + LG + CRC_WIDTH;

    localparam logic [NB-1:0]        LANE_ALL = {NB{1'b1}};
    localparam logic [NB-1:0]        LANE_ONE = {{(NB-1){1'b0}}, 1'b1};
    localparam logic [CBW-1:0]       CB_CNT   = CBW'(CB);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CRC_WIDTH-1:0] CRC_ZERO = {CRC_WIDTH{1'b0}};

    // Advance a CRC state over a full beat, top lane first, bits MSB-first
    // (LSB-first when input reflection is on). With a zero state this is the
    // data-only contribution; with zero data it is the state-only contribution.
    function automatic logic [CRC_WIDTH-1:0] crc_adv(input logic [CRC_WIDTH-1:0] st,
                                                     input logic [DWIDTH-1:0]    d);
        logic [CRC_WIDTH-1:0] s;
        logic                 fb;
        s = st;
        for (int ln = NB - 1; ln >= 0; ln--) begin
            for (int b = 0; b < 8; b++) begin
                fb = s[CRC_WIDTH-1] ^ (REFIN ? d[8*ln+b] : d[8*ln+7-b]);
                s  = {s[CRC_WIDTH-2:0], 1'b0} ^ (fb ? CRC_POLY : CRC_ZERO);
            end
        end
        return s;
    endfunction

    // Undo nbits zero-input shifts. The polynomial's x^0 term makes bit 0
    // of a shifted state equal the bit that fell out of the top.
    function automatic logic [CRC_WIDTH-1:0] crc_unshift(input logic [CRC_WIDTH-1:0] st,
                                                         input int                   nbits);
        logic [CRC_WIDTH-1:0] s;
        logic                 fb;
        s = st;
        for (int k = 0; k < DWIDTH; k++) begin
            if (k < nbits) begin
                fb = s[0];
                s  = (s ^ (fb ? CRC_POLY : CRC_ZERO)) >> 1;
                s[CRC_WIDTH-1] = fb;
            end
        end
        return s;
    endfunction

    // Number of enabled lanes.
    function automatic logic [LG:0] lane_pop(input logic [NB-1:0] m);
        logic [LG:0] c;
        c = {(LG+1){1'b0}};
        for (int i = 0; i < NB; i++) begin
            c = c + {{LG{1'b0}}, m[i]};
        end
        return c;
    endfunction

    // Index of the lowest enabled lane = count of disabled tail lanes.
    function automatic logic [LG-1:0] lane_ctz(input logic [NB-1:0] m);
        logic [LG-1:0] z;
        z = {LG{1'b0}};
        for (int i = NB - 1; i >= 0; i--) begin
            if (m[i]) begin
                z = LG'(i);
            end
        end
        return z;
    endfunction

    // ---------------- input-side framing checks ----------------
    logic              r_in_frame;
    logic              r_fmt_acc;
    logic [CBW-1:0]    r_bcnt;

    logic [NB-1:0]     w_inv;
    logic              w_contig;
    logic              w_beat_bad;
    logic [LG:0]       w_pop;
    logic [CBW-1:0]    w_base;
    logic [SW-1:0]     w_sum;
    logic [CBW-1:0]    w_cnt_new;
    logic              w_fmt_now;
    logic              w_runt;
    logic [DWIDTH-1:0] w_din_m;

    // Beat-rule check, sticky format flag and saturating byte count for the current beat.
    always_comb begin
        w_inv      = ~byteEn;
        w_contig   = ((w_inv & (w_inv + LANE_ONE)) == {NB{1'b0}}) && (byteEn != {NB{1'b0}});
        w_beat_bad = !w_contig || (!dlast && (byteEn != LANE_ALL));
        w_pop      = lane_pop(byteEn);
        w_base     = r_in_frame ? r_bcnt : {CBW{1'b0}};
        w_sum      = SW'(w_base) + SW'(w_pop);
        w_cnt_new  = (w_sum >= SW'(CB)) ? CB_CNT : w_sum[CBW-1:0];
        w_fmt_now  = (r_in_frame & r_fmt_acc) | w_beat_bad;
        w_runt     = (w_cnt_new < CB_CNT);
    end

    // Zero disabled lanes so they act as trailing zero bytes.
    always_comb begin
        w_din_m = {DWIDTH{1'b0}};
        for (int ln = 0; ln < NB; ln++) begin
            w_din_m[8*ln +: 8] = byteEn[ln] ? din[8*ln +: 8] : 8'h00;
        end
    end

    // Frame tracking: IN_FRAME, sticky format flag and byte count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_frame <= 1'b0;
            r_fmt_acc  <= 1'b0;
            r_bcnt     <= {CBW{1'b0}};
        end else if (flitEn) begin
            if (dlast) begin
                r_in_frame <= 1'b0;
                r_fmt_acc  <= 1'b0;
                r_bcnt     <= {CBW{1'b0}};
            end else begin
                r_in_frame <= 1'b1;
                r_fmt_acc  <= w_fmt_now;
                r_bcnt     <= w_cnt_new;
            end
        end
    end

    // ---------------- input register ----------------
    logic              r_in_vld;
    logic              r_in_last;
    logic [DWIDTH-1:0] r_in_data;
    logic [LG-1:0]     r_in_nz;
    logic              r_in_fmt;

    // Capture the masked beat together with its tail-lane count and frame verdict.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_vld  <= 1'b0;
            r_in_last <= 1'b0;
            r_in_data <= {DWIDTH{1'b0}};
            r_in_nz   <= {LG{1'b0}};
            r_in_fmt  <= 1'b0;
        end else begin
            r_in_vld  <= flitEn;
            r_in_last <= flitEn & dlast;
            if (flitEn) begin
                r_in_data <= w_din_m;
                r_in_nz   <= lane_ctz(byteEn);
                r_in_fmt  <= w_fmt_now | w_runt;
            end
        end
    end

    // ---------------- data XOR tree and its pipeline ----------------
    logic [CRC_WIDTH-1:0] w_b;
    logic [BW-1:0]        w_p0;
    logic [BW-1:0]        w_pn;

    assign w_b  = crc_adv(CRC_ZERO, r_in_data);
    assign w_p0 = {r_in_vld, r_in_last, r_in_nz, r_in_fmt, w_b};

    generate
        if (PIPE_LVL == 0) begin : g_nopipe
            assign w_pn = w_p0;
        end else begin : g_pipe
            logic [BW-1:0] r_pipe [PIPE_LVL];
            // Delay line for the data-only CRC term and its beat sideband.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < PIPE_LVL; i++) begin
                        r_pipe[i] <= {BW{1'b0}};
                    end
                end else begin
                    r_pipe[0] <= w_p0;
                    for (int i = 1; i < PIPE_LVL; i++) begin
                        r_pipe[i] <= r_pipe[i-1];
                    end
                end
            end
            assign w_pn = r_pipe[PIPE_LVL-1];
        end
    endgenerate

    logic                 w_a_vld;
    logic                 w_a_last;
    logic [LG-1:0]        w_a_nz;
    logic                 w_a_fmt;
    logic [CRC_WIDTH-1:0] w_a_b;
    logic [CRC_WIDTH-1:0] w_crc_next;

    assign w_a_vld  = w_pn[BW-1];
    assign w_a_last = w_pn[BW-2];
    assign w_a_nz   = w_pn[CRC_WIDTH+1 +: LG];
    assign w_a_fmt  = w_pn[CRC_WIDTH];
    assign w_a_b    = w_pn[CRC_WIDTH-1:0];

    // ---------------- accumulate and tail revert ----------------
    logic [CRC_WIDTH-1:0] r_crc;
    logic [CRC_WIDTH-1:0] r_st_crc [LG+1];
    logic                 r_st_vld [LG+1];
    logic                 r_st_fmt [LG+1];
    logic [LG-1:0]        r_st_nz  [LG];
    logic [CRC_WIDTH-1:0] w_rv_crc [LG];

    // Linear split: the new state is the old state advanced over a zero beat, XOR the data term.
    assign w_crc_next = crc_adv(r_crc, {DWIDTH{1'b0}}) ^ w_a_b;

    // Stage s backs out 8*2^(LG-1-s) bits when that bit of the tail count is set.
    always_comb begin
        for (int s = 0; s < LG; s++) begin
            w_rv_crc[s] = r_st_nz[s][LG-1-s]
                        ? crc_unshift(r_st_crc[s], int'(32'd8 << (LG - 1 - s)))
                        : r_st_crc[s];
        end
    end

    // CRC register update, frame-end capture and the fixed-length revert chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_crc <= INIT;
            for (int s = 0; s <= LG; s++) begin
                r_st_crc[s] <= CRC_ZERO;
                r_st_vld[s] <= 1'b0;
                r_st_fmt[s] <= 1'b0;
            end
            for (int s = 0; s < LG; s++) begin
                r_st_nz[s] <= {LG{1'b0}};
            end
        end else begin
            if (w_a_vld) begin
                r_crc <= w_a_last ? INIT : w_crc_next;
            end
            r_st_vld[0] <= w_a_vld & w_a_last;
            r_st_crc[0] <= w_crc_next;
            r_st_fmt[0] <= w_a_fmt;
            r_st_nz[0]  <= w_a_nz;
            for (int s = 0; s < LG; s++) begin
                r_st_vld[s+1] <= r_st_vld[s];
                r_st_crc[s+1] <= w_rv_crc[s];
                r_st_fmt[s+1] <= r_st_fmt[s];
            end
            for (int s = 0; s < LG - 1; s++) begin
                r_st_nz[s+1] <= r_st_nz[s];
            end
        end
    end

    // ---------------- result and counters ----------------
    logic                 r_chk_vld;
    logic                 r_chk_ok;
    logic                 r_chk_crc;
    logic                 r_chk_fmt;
    logic [CNT_WIDTH-1:0] r_frame_cnt;
    logic [CNT_WIDTH-1:0] r_err_cnt;
    logic                 w_res_bad;

    assign w_res_bad = (r_st_crc[LG] != RESIDUE);

    // Registered per-frame verdict; flags read 0 whenever no strobe is presented.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_chk_vld <= 1'b0;
            r_chk_ok  <= 1'b0;
            r_chk_crc <= 1'b0;
            r_chk_fmt <= 1'b0;
        end else begin
            r_chk_vld <= r_st_vld[LG];
            r_chk_fmt <= r_st_vld[LG] & r_st_fmt[LG];
            r_chk_crc <= r_st_vld[LG] & !r_st_fmt[LG] & w_res_bad;
            r_chk_ok  <= r_st_vld[LG] & !r_st_fmt[LG] & !w_res_bad;
        end
    end

    // Saturating statistics, updated the cycle after each strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_cnt <= {CNT_WIDTH{1'b0}};
            r_err_cnt   <= {CNT_WIDTH{1'b0}};
        end else if (r_chk_vld) begin
            if (r_frame_cnt != CNT_MAX) begin
                r_frame_cnt <= r_frame_cnt + CNT_ONE;
            end
            if (!r_chk_ok && (r_err_cnt != CNT_MAX)) begin
                r_err_cnt <= r_err_cnt + CNT_ONE;
            end
        end
    end

    assign chk_vld     = r_chk_vld;
    assign chk_ok      = r_chk_ok;
    assign chk_crc_err = r_chk_crc;
    assign chk_fmt_err = r_chk_fmt;
    assign frame_cnt   = r_frame_cnt;
    assign err_cnt     = r_err_cnt;

endmodule

// File: tb/tb_crc_chk_byteen.sv
// Randomised scoreboard bench for crc_chk_byteen (64-bit datapath, CRC-16).
// The stimulus side builds frames, derives each verdict from a bit-serial CRC
// over the wire bytes and queues it with its due cycle; a negedge monitor
// pops and checks results, latency, idle outputs and counters.
module tb_crc_chk_byteen;

    localparam int DW  = 64;
    localparam int LAT = 0 + 3 + 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] din = 64'h0;
    logic [7:0]  byteEn = 8'h00;
    logic        dlast = 1'b0;
    logic        flitEn = 1'b0;

    logic        chk_vld, chk_ok, chk_crc_err, chk_fmt_err;
    logic [31:0] frame_cnt, err_cnt;
    logic        s_vld, s_ok, s_crc, s_fmt;
    logic [3:0]  s_frame_cnt, s_err_cnt;

    crc_chk_byteen #(.DWIDTH(DW), .CRC_WIDTH(16)) u_dut (
        .clk(clk), .rst(rst), .din(din), .byteEn(byteEn), .dlast(dlast), .flitEn(flitEn),
        .chk_vld(chk_vld), .chk_ok(chk_ok), .chk_crc_err(chk_crc_err), .chk_fmt_err(chk_fmt_err),
        .frame_cnt(frame_cnt), .err_cnt(err_cnt));

    crc_chk_byteen #(.DWIDTH(DW), .CRC_WIDTH(16), .CNT_WIDTH(4)) u_sat (
        .clk(clk), .rst(rst), .din(din), .byteEn(byteEn), .dlast(dlast), .flitEn(flitEn),
        .chk_vld(s_vld), .chk_ok(s_ok), .chk_crc_err(s_crc), .chk_fmt_err(s_fmt),
        .frame_cnt(s_frame_cnt), .err_cnt(s_err_cnt));

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          ok;
        bit          crc;
        bit          fmt;
        int unsigned at;
    } exp_t;
    typedef bit [7:0] byte_q_t [$];

    exp_t    sb[$];
    int      total = 0;
    int      bad = 0;
    longint  mfc = 0;
    longint  mec = 0;
    bit      fin_req = 1'b0;
    bit      fin_done = 1'b0;
    exp_t    mon_e;

    // Textbook bit-serial CRC-16 (poly 0xDA5F, init 0, MSB-first) over wire-order bytes.
    function automatic bit [15:0] model_crc(input byte_q_t b);
        bit [15:0] s;
        bit        fb;
        s = 16'h0000;
        foreach (b[i]) begin
            for (int k = 7; k >= 0; k--) begin
                fb = s[15] ^ b[i][k];
                s  = {s[14:0], 1'b0} ^ (fb ? 16'hda5f : 16'h0000);
            end
        end
        return s;
    endfunction

    // A legal mask keeps the top k lanes for some k in 1..8.
    function automatic bit mask_ok(input bit [7:0] be);
        bit [7:0] m;
        for (int k = 1; k <= 8; k++) begin
            m = 8'hFF << (8 - k);
            if (be == m) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            mfc = 0;
            mec = 0;
        end else begin
            chk("frame_cnt", longint'(frame_cnt), mfc);
            chk("err_cnt", longint'(err_cnt), mec);
            chk("sat_frame_cnt", longint'(s_frame_cnt), (mfc > 15) ? 15 : mfc);
            chk("sat_err_cnt", longint'(s_err_cnt), (mec > 15) ? 15 : mec);
            if (chk_vld) begin
                if (sb.size() == 0) begin
                    chk("unexpected_vld", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("latency_cycle", longint'(cyc), longint'(mon_e.at));
                    chk("chk_ok", longint'(chk_ok), longint'(mon_e.ok));
                    chk("chk_crc_err", longint'(chk_crc_err), longint'(mon_e.crc));
                    chk("chk_fmt_err", longint'(chk_fmt_err), longint'(mon_e.fmt));
                    mfc++;
                    if (!mon_e.ok) mec++;
                end
            end else begin
                chk("idle_flags", longint'({chk_ok, chk_crc_err, chk_fmt_err}), 0);
                if (sb.size() > 0 && cyc >= sb[0].at) begin
                    chk("missing_vld_timeout", 0, 1);
                    void'(sb.pop_front());
                end
            end
            if (fin_req && !fin_done) begin
                chk("sat_frame_hold", longint'(s_frame_cnt), 15);
                chk("sat_err_hold", longint'(s_err_cnt), 15);
                fin_done = 1'b1;
            end
        end
    end

    byte_q_t m_bytes;
    bit      m_fmt = 1'b0;

    task automatic drive_beat(input bit [63:0] d, input bit [7:0] be, input bit last);
        exp_t      e;
        bit [15:0] r;
        bit        f;
        @(posedge clk); #1;
        din = d; byteEn = be; dlast = last; flitEn = 1'b1;
        if (!mask_ok(be) || (!last && be != 8'hFF)) m_fmt = 1'b1;
        for (int l = 7; l >= 0; l--) if (be[l]) m_bytes.push_back(d[8*l +: 8]);
        if (last) begin
            r     = model_crc(m_bytes);
            f     = m_fmt || (m_bytes.size() < 2);
            e.fmt = f;
            e.crc = !f && (r != 16'h0000);
            e.ok  = !f && (r == 16'h0000);
            e.at  = cyc + 1 + LAT;
            sb.push_back(e);
            m_bytes.delete();
            m_fmt = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            flitEn = 1'b0;
            din    = {$urandom, $urandom};
            byteEn = 8'($urandom);
            dlast  = 1'($urandom);
        end
    endtask

    // Payload + generated FCS, optional single bit flip, optional in-frame gaps.
    task automatic send_frame(input int plen, input bit corrupt, input bit gaps);
        byte_q_t   f;
        bit [15:0] c;
        bit [63:0] d;
        int        pos, k, idx;
        for (int i = 0; i < plen; i++) f.push_back(8'($urandom));
        c = model_crc(f);
        f.push_back(c[15:8]);
        f.push_back(c[7:0]);
        if (corrupt) begin
            idx = $urandom_range(0, f.size() - 1);
            f[idx][$urandom_range(0, 7)] ^= 1'b1;
        end
        pos = 0;
        while (pos < f.size()) begin
            k = (f.size() - pos > 8) ? 8 : f.size() - pos;
            d = {$urandom, $urandom};
            for (int j = 0; j < k; j++) d[8*(7-j) +: 8] = f[pos+j];
            drive_beat(d, 8'hFF << (8 - k), (pos + k) == f.size());
            pos += k;
            if (gaps && pos < f.size() && $urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst = 1'b1; flitEn = 1'b0;
        m_bytes.delete();
        m_fmt = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        idle(3);

        // Clean frame with partial tail, then the same frame with din[0] flipped.
        drive_beat(64'h0, 8'hFF, 1'b0);
        drive_beat(64'h0, 8'hC0, 1'b1);
        idle(8);
        drive_beat(64'h1, 8'hFF, 1'b0);
        drive_beat(64'h0, 8'hC0, 1'b1);
        idle(8);

        // Back-to-back single-beat frames cycling the tail masks.
        for (int i = 0; i < 1000; i++) begin
            case (i % 4)
                0:       send_frame(6, 1'b0, 1'b0);
                1:       send_frame(5, 1'b0, 1'b0);
                2:       send_frame(2, 1'b0, 1'b0);
                default: send_frame(0, 1'b0, 1'b0);
            endcase
        end
        idle(8);

        // Framing violations.
        drive_beat({$urandom, $urandom}, 8'h80, 1'b1);
        drive_beat({$urandom, $urandom}, 8'hA0, 1'b1);
        drive_beat({$urandom, $urandom}, 8'hF0, 1'b0);
        drive_beat({$urandom, $urandom}, 8'hFF, 1'b1);
        drive_beat({$urandom, $urandom}, 8'h00, 1'b1);
        idle(10);

        // Reset in the middle of a two-beat frame, then a clean frame.
        drive_beat({$urandom, $urandom}, 8'hFF, 1'b0);
        pulse_reset();
        idle(3);
        send_frame(8, 1'b0, 1'b0);
        idle(10);

        // Random multi-beat frames with gaps and occasional corruption.
        for (int i = 0; i < 150; i++) begin
            send_frame($urandom_range(0, 30), $urandom_range(0, 3) == 0, 1'b1);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
        end

        // Twenty erroneous frames to drive the narrow counters to saturation.
        for (int i = 0; i < 20; i++) send_frame(4, 1'b1, 1'b0);
        idle(20);

        fin_req = 1'b1;
        idle(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/crc_chk_byteen.md
# crc_chk_byteEn

Receive-side CRC checker for the byte-enabled streaming datapath. It consumes frames whose last `CRC_WIDTH/8` valid bytes are the transmitted FCS and computes the CRC over the whole frame, FCS included. It compares the final CRC register against a fixed residue and reports one pass/fail result per frame. It also flags malformed byte-enable framing and keeps saturating frame and error counters for the link status block.

## Interface
- `DWIDTH`, 512: datapath width in bits; multiple of 8, greater than 8.
- `CRC_WIDTH`, 16: CRC width; multiple of 8.
- `PIPE_LVL`, 0: number of register levels in the data XOR tree.
- `CRC_POLY`, 16'hda5f: generator polynomial, implicit top bit.
- `INIT`, 16'b0: CRC register value at frame start.
- `REFIN`, 1'b0: reflect each input byte.
- `RESIDUE`, 16'b0: expected internal CRC register after the FCS, before output reflection or XOR.
- `CNT_WIDTH`, 32: width of the statistics counters.

Ports:
- `clk`, input, 1: single clock.
- `rst`, input, 1: synchronous, active-high reset.
- `din`, input, DWIDTH: beat data; byte lane i is `din[8i+7:8i]`; lane DWIDTH/8-1 is the first byte on the wire, and each byte is processed MSB-first.
- `byteEn`, input, DWIDTH/8: lane valid mask.
- `dlast`, input, 1: last beat of the frame.
- `flitEn`, input, 1: beat valid; no backpressure.
- `chk_vld`, output, 1: one-cycle result strobe.
- `chk_ok`, output, 1: frame passed; qualified by `chk_vld`.
- `chk_crc_err`, output, 1: residue mismatch; qualified by `chk_vld`.
- `chk_fmt_err`, output, 1: framing violation; qualified by `chk_vld`.
- `frame_cnt`, output, CNT_WIDTH: frames checked, saturating.
- `err_cnt`, output, CNT_WIDTH: frames with `chk_ok`=0, saturating.

## Operation
- **Beat rules:**
  - `byteEn` must be contiguous from the top lane down, i.e. of the form 1…10…0, and nonzero.
  - Every beat other than the `dlast` beat must have all lanes enabled.
- **Datapath:**
  - Disabled lanes are zeroed.
  - The per-beat CRC update is a fully parallel XOR network over `DWIDTH` bits, pipelined by `PIPE_LVL` levels.
  - On the `dlast` beat, the zero padding from `n` disabled lanes is cancelled by `n` reverse byte-shifts of the CRC register. These are implemented as `$clog2(DWIDTH/8)` conditional stages, where stage i shifts back by 8·2^(clog2−1−i) bits, so the revert latency is fixed.
  - The CRC register reloads `INIT` after each `dlast` beat.
- **Frame state:** IN_FRAME flag.
  - It sets on the first `flitEn` beat and clears on the `dlast` beat.
  - A single beat with `dlast`=1 is a whole frame.
- **Sticky per-frame `fmt` flag:**
  - Set by any beat-rule violation in the frame.
  - Set if the total valid byte count at `dlast` is below `CRC_WIDTH/8` (runt frame).
  - The byte count saturates at `CRC_WIDTH/8`.
- **Result of each frame:**
  - `chk_fmt_err` = `fmt`.
  - `chk_crc_err` = (final register ≠ `RESIDUE`) && !`fmt`.
  - `chk_ok` = !`chk_fmt_err` && !`chk_crc_err`.
  - Exactly one `chk_vld` is produced per `dlast` beat.
- **Counters:**
  - `frame_cnt` increments on every `chk_vld`.
  - `err_cnt` increments on `chk_vld` with `chk_ok`=0.
  - Both hold at all-ones.
- **Idle beats:** beats with `flitEn`=0 are ignored; `din` and `byteEn` are don't-care.

## Timing
- **Reset values:** all outputs are 0 after `rst`. The CRC register resets to `INIT`, and all pipeline valids and the IN_FRAME flag clear.
- **Latency:** `chk_vld` asserts exactly LAT = `PIPE_LVL` + `$clog2(DWIDTH/8)` + 2 cycles after the clock edge sampling the `dlast` beat. LAT is independent of the `byteEn` pattern.
- **Result outputs:** `chk_ok`, `chk_crc_err` and `chk_fmt_err` are registered. They are valid only while `chk_vld`=1 and are 0 otherwise.
- **Counters:** `frame_cnt` and `err_cnt` reflect a result on the cycle after its `chk_vld`.
- **Throughput:** one beat per cycle, including consecutive single-beat frames (`dlast`=1 every cycle). Results emerge in order, one per cycle, with no bubbles.
- **Gaps:** idle cycles inside a frame are permitted and do not alter the result or the latency, which is counted from `dlast`.
- **Reset mid-frame:** in-flight frames are discarded and no `chk_vld` is produced for them. The next `flitEn` beat starts a fresh frame.
- **Reset with `chk_vld` pending:** the result is suppressed.

## Test plan
Unless noted, benches use DWIDTH=64, CRC_WIDTH=16, defaults otherwise.
- **Clean frame, partial tail:** 10 zero bytes (beat 1 `byteEn`=8'hFF, beat 2 `byteEn`=8'hC0, `dlast`) → `chk_vld` at LAT=5 after beat 2; `chk_ok`=1; `frame_cnt`=1; `err_cnt`=0.
- **Corrupted bit:** same frame with `din[0]` of beat 1 flipped → `chk_crc_err`=1, `chk_ok`=0, `err_cnt`=1.
- **Back-to-back single-beat frames:** payloads with generator-computed FCS, `byteEn` cycling 8'hFF, 8'hFE, 8'hF0, 8'hC0 over 1000 beats with `dlast` every beat → 1000 consecutive `chk_vld` pulses, all `chk_ok`=1; compare against a bit-serial reference model.
- **Framing violations:**
  - Runt frame, 1 byte (`byteEn`=8'h80, `dlast`) → `chk_fmt_err`=1.
  - `byteEn`=8'hA0 on the last beat → `chk_fmt_err`=1.
  - `byteEn`=8'hF0 on a non-last beat → `chk_fmt_err`=1, and `chk_crc_err`=0 in each case.
- **Reset mid-frame:** `rst` for 1 cycle after beat 1 of a 2-beat frame → no `chk_vld`; all outputs 0. The following clean frame → `chk_ok`=1, `frame_cnt`=1.
- **Counter saturation:** build with CNT_WIDTH=4 and send 20 erroneous frames → `frame_cnt` and `err_cnt` hold at 4'hF.
